// File: rtl/btb_wr_sched.sv
// btb_wr_sched: arbitrates speculative and retire BTB writes through a retire FIFO; optional starvation guard via BTB_STARVE_GUARD_EN
module btb_wr_sched #(
  parameter int QDEPTH     = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    spec_vld_i,
  output logic                    spec_rdy_o,
  input  logic [2:0]              spec_brpos_i,
  input  logic [1:0]              spec_brtyp_i,
  input  logic [1:0]              spec_rasctl_i,
  input  logic [63:0]             spec_brpc_i,
  input  logic [63:0]             spec_brtar_i,
  input  logic                    cert_vld_i,
  output logic                    cert_rdy_o,
  input  logic                    cert_brdir_i,
  input  logic [63:0]             cert_brpc_i,
  input  logic [63:0]             cert_brtar_i,
  input  logic                    flush_i,
  output logic                    btb_we_spec_o,
  output logic [2:0]              btb_brpos_spec_o,
  output logic [1:0]              btb_brtyp_spec_o,
  output logic [1:0]              btb_rasctl_o,
  output logic [63:0]             btb_brpc_spec_o,
  output logic [63:0]             btb_brtar_spec_o,
  output logic                    btb_we_cert_o,
  output logic                    btb_brdir_cert_o,
  output logic [63:0]             btb_brpc_cert_o,
  output logic [63:0]             btb_brtar_cert_o,
  output logic [$clog2(QDEPTH):0] q_cnt_o
);
  localparam int AW = $clog2(QDEPTH);
  logic [QDEPTH-1:0] r_dir;
  logic [63:0]       r_pc  [QDEPTH];
  logic [63:0]       r_tar [QDEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_cnt;
  logic              w_empty, w_push, w_gnt_spec, w_gnt_cert;
  assign w_empty    = r_cnt == '0;
  assign cert_rdy_o = r_cnt < (AW+1)'(QDEPTH);
  assign w_push     = cert_vld_i & cert_rdy_o & ~flush_i;
  assign w_gnt_spec = spec_vld_i & spec_rdy_o;
  assign w_gnt_cert = ~w_gnt_spec & ~w_empty & ~flush_i;
  assign q_cnt_o    = r_cnt;
`ifdef BTB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] r_starve;
  logic          w_force;
  assign w_force    = r_starve == SW'(STARVE_LIM);
  assign spec_rdy_o = ~w_force;
  // count spec wins over a waiting queue; a forced cycle hands the port to the head
  always_ff @(posedge clock or posedge reset)
    if (reset) r_starve <= '0;
    else if (w_force || w_gnt_cert || w_empty) r_starve <= '0;
    else if (w_gnt_spec) r_starve <= r_starve + 1'b1;
`else
  assign spec_rdy_o = (STARVE_LIM != 0) | 1'b1;
`endif
  // queue storage; payload validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clock)
    if (w_push) begin
      r_dir[r_wp] <= cert_brdir_i;
      r_pc[r_wp]  <= cert_brpc_i;
      r_tar[r_wp] <= cert_brtar_i;
    end
  // queue pointers and occupancy; flush empties the queue outright
  always_ff @(posedge clock or posedge reset)
    if (reset || flush_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_gnt_cert) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_gnt_cert);
    end
  // registered BTB write ports, payload zeroed whenever the strobe is low
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      btb_we_spec_o    <= 1'b0;
      btb_brpos_spec_o <= '0;
      btb_brtyp_spec_o <= '0;
      btb_rasctl_o     <= '0;
      btb_brpc_spec_o  <= '0;
      btb_brtar_spec_o <= '0;
      btb_we_cert_o    <= 1'b0;
      btb_brdir_cert_o <= 1'b0;
      btb_brpc_cert_o  <= '0;
      btb_brtar_cert_o <= '0;
    end else begin
      btb_we_spec_o    <= w_gnt_spec;
      btb_brpos_spec_o <= w_gnt_spec ? spec_brpos_i : '0;
      btb_brtyp_spec_o <= w_gnt_spec ? spec_brtyp_i : '0;
      btb_rasctl_o     <= w_gnt_spec ? spec_rasctl_i : '0;
      btb_brpc_spec_o  <= w_gnt_spec ? spec_brpc_i : '0;
      btb_brtar_spec_o <= w_gnt_spec ? spec_brtar_i : '0;
      btb_we_cert_o    <= w_gnt_cert;
      btb_brdir_cert_o <= w_gnt_cert & r_dir[r_rp];
      btb_brpc_cert_o  <= w_gnt_cert ? r_pc[r_rp] : '0;
      btb_brtar_cert_o <= w_gnt_cert ? r_tar[r_rp] : '0;
    end
endmodule
